// File: rtl/pwm_decoder_pkg.sv
// Shared types, constants and helpers for the PWM sample decoder.
// Used by pwm_sample_decoder and pulse_input_conditioner.
package pwm_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2
    } dec_state_t;

    localparam int SYNC_STAGES = 2;
    localparam int FILTER_TAPS = 3;

    // Clamp a count to the largest value representable in i_w bits.
    function automatic logic [31:0] sat_trunc(
        input logic [31:0] i_val,
        input int unsigned i_w
    );
        logic [31:0] w_max;
        if (i_w >= 32) begin
            w_max = 32'hFFFF_FFFF;
        end else begin
            w_max = (32'd1 << i_w) - 32'd1;
        end
        return (i_val > w_max) ? w_max : i_val;
    endfunction

endpackage

// File: rtl/pulse_input_conditioner.sv
// Pulse synchroniser, optional majority filter and rising-edge detect.
// PWM_DECODER_GLITCH_FILTER_EN inserts a 3-tap majority filter (+2 cycles).
module pulse_input_conditioner
    import pwm_decoder_pkg::*;
(
    input  logic sysclk,
    input  logic reset,
    input  logic Pulse,
    output logic p_s,
    output logic p_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_p_d;
    logic                   w_level;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], Pulse};
        end
    end

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    logic [FILTER_TAPS-2:0] r_hist;
    logic [FILTER_TAPS-1:0] w_taps;
    logic                   r_filt;

    assign w_taps = {r_hist, r_sync[SYNC_STAGES-1]};

    // Registered vote so a step emerges exactly two cycles late.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_hist <= '0;
            r_filt <= 1'b0;
        end else begin
            r_hist <= w_taps[FILTER_TAPS-2:0];
            r_filt <= ($countones(w_taps) > (FILTER_TAPS / 2));
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_p_d <= 1'b0;
        end else begin
            r_p_d <= w_level;
        end
    end

    assign p_s    = w_level;
    assign p_rise = w_level & ~r_p_d;

endmodule

// File: rtl/pwm_sample_decoder.sv
// Recovers one saturated high-count sample per fixed PWM frame.
// Build option: PWM_DECODER_GLITCH_FILTER_EN (majority filter on Pulse).
module pwm_sample_decoder
    import pwm_decoder_pkg::*;
#(
    parameter int PERIOD_CYCLES = 256,
    parameter int SAMPLE_W      = 8
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic                Enable_SW_1,
    input  logic                Pulse,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                locked,
    output logic                frame_err
);

    localparam int PW = $clog2(PERIOD_CYCLES);
    localparam int HW = $clog2(PERIOD_CYCLES + 1);
    localparam logic [PW-1:0] P_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [PW-1:0] P_ONE  = PW'(1);
    localparam logic [HW-1:0] H_ONE  = HW'(1);

    dec_state_t          r_state;
    dec_state_t          w_state_nx;
    logic [PW-1:0]       r_period;
    logic [PW-1:0]       w_period_nx;
    logic [HW-1:0]       r_high;
    logic [HW-1:0]       w_high_nx;
    logic [HW-1:0]       w_high_acc;
    logic [SAMPLE_W-1:0] r_sample;
    logic [SAMPLE_W-1:0] w_sample_nx;
    logic                r_valid;
    logic                w_valid_nx;
    logic                r_locked;
    logic                w_locked_nx;
    logic                r_ferr;
    logic                w_ferr_nx;
    logic                w_p_s;
    logic                w_p_rise;

    pulse_input_conditioner u_cond (
        .sysclk (sysclk),
        .reset  (reset),
        .Pulse  (Pulse),
        .p_s    (w_p_s),
        .p_rise (w_p_rise)
    );

    assign w_high_acc = r_high + {{(HW-1){1'b0}}, w_p_s};

    always_comb begin
        w_state_nx  = r_state;
        w_period_nx = r_period;
        w_high_nx   = r_high;
        w_sample_nx = r_sample;
        w_valid_nx  = 1'b0;
        w_locked_nx = r_locked;
        w_ferr_nx   = 1'b0;
        if (!Enable_SW_1) begin
            w_state_nx  = IDLE;
            w_period_nx = '0;
            w_high_nx   = '0;
            w_locked_nx = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_nx  = ACQUIRE;
                    w_period_nx = '0;
                    w_high_nx   = '0;
                    w_locked_nx = 1'b0;
                end
                ACQUIRE: begin
                    if (w_p_rise) begin
                        w_state_nx  = TRACK;
                        w_period_nx = P_ONE;
                        w_high_nx   = H_ONE;
                    end
                end
                TRACK: begin
                    // An edge away from count 0 restarts the frame there.
                    if (w_p_rise && (r_period != '0)) begin
                        w_ferr_nx   = 1'b1;
                        w_locked_nx = 1'b0;
                        w_period_nx = P_ONE;
                        w_high_nx   = H_ONE;
                    end else if (r_period == P_LAST) begin
                        w_sample_nx = SAMPLE_W'(
                            sat_trunc(32'(w_high_acc), SAMPLE_W));
                        w_valid_nx  = 1'b1;
                        w_locked_nx = 1'b1;
                        w_period_nx = '0;
                        w_high_nx   = '0;
                    end else begin
                        w_period_nx = r_period + P_ONE;
                        w_high_nx   = w_high_acc;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_period <= '0;
            r_high   <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_period <= w_period_nx;
            r_high   <= w_high_nx;
            r_sample <= w_sample_nx;
            r_valid  <= w_valid_nx;
            r_locked <= w_locked_nx;
            r_ferr   <= w_ferr_nx;
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign locked       = r_locked;
    assign frame_err    = r_ferr;

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// Directed bench for pwm_sample_decoder (256-cycle frames, 8-bit samples).
// Latency constants grow by 2 when PWM_DECODER_GLITCH_FILTER_EN is defined.
`timescale 1ns/1ps
module tb_pwm_sample_decoder;

    localparam int P = 256;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    localparam int L = 4;
`else
    localparam int L = 2;
`endif

    logic       sysclk      = 1'b0;
    logic       reset       = 1'b1;
    logic       Enable_SW_1 = 1'b0;
    logic       Pulse       = 1'b0;
    logic [7:0] sample;
    logic       sample_valid;
    logic       locked;
    logic       frame_err;

    int   cyc         = 0;
    int   n_err       = 0;
    int   n_chk       = 0;
    int   n_ferr      = 0;
    int   ferr_cyc    = -1;
    logic ferr_locked = 1'b1;
    int   q_cyc[$];
    int   q_samp[$];

    pwm_sample_decoder #(
        .PERIOD_CYCLES (P),
        .SAMPLE_W      (8)
    ) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .Enable_SW_1  (Enable_SW_1),
        .Pulse        (Pulse),
        .sample       (sample),
        .sample_valid (sample_valid),
        .locked       (locked),
        .frame_err    (frame_err)
    );

    always #10 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        if (sample_valid === 1'b1) begin
            q_cyc.push_back(cyc);
            q_samp.push_back(int'(sample));
        end
        if (frame_err === 1'b1) begin
            n_ferr++;
            ferr_cyc    = cyc;
            ferr_locked = locked;
        end
    end

    function automatic int qc(input int i);
        return (i < q_cyc.size()) ? q_cyc[i] : -1;
    endfunction

    function automatic int qs(input int i);
        return (i < q_samp.size()) ? q_samp[i] : -1;
    endfunction

    task automatic qclear();
        q_cyc.delete();
        q_samp.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    task automatic pwm_part(input int n, input int high);
        for (int i = 0; i < n; i++) begin
            @(negedge sysclk);
            Pulse = (i < high);
        end
    endtask

    task automatic pwm_frames(input int nf, input int high,
                              output int t0);
        t0 = -1;
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < P; i++) begin
                @(negedge sysclk);
                Pulse = (i < high);
                if (t0 < 0) t0 = cyc;
            end
        end
    endtask

    task automatic test_reset();
        idle(5);
        n_chk++;
        if (sample !== 8'd0) begin
            n_err++;
            $display("FAIL rst_sample: got %0d want 0", sample);
        end
        n_chk++;
        if (sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_valid: got %b want 0", sample_valid);
        end
        n_chk++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL rst_locked: got %b want 0", locked);
        end
        n_chk++;
        if (frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_ferr: got %b want 0", frame_err);
        end
        @(negedge sysclk);
        reset = 1'b0;
    endtask

    task automatic test_duty25();
        int t0;
        Enable_SW_1 = 1'b1;
        idle(5);
        n_chk++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL acq_locked: got %b want 0", locked);
        end
        qclear();
        pwm_frames(4, 64, t0);
        n_chk++;
        if (q_cyc.size() !== 3) begin
            n_err++;
            $display("FAIL d25_count: got %0d want 3", q_cyc.size());
        end
        n_chk++;
        if (qc(0) !== t0 + P + L) begin
            n_err++;
            $display("FAIL d25_first: got %0d want %0d",
                     qc(0), t0 + P + L);
        end
        n_chk++;
        if (qc(2) - qc(1) !== P) begin
            n_err++;
            $display("FAIL d25_space: got %0d want %0d",
                     qc(2) - qc(1), P);
        end
        n_chk++;
        if (qs(0) !== 64) begin
            n_err++;
            $display("FAIL d25_s0: got %0d want 64", qs(0));
        end
        n_chk++;
        if (qs(2) !== 64) begin
            n_err++;
            $display("FAIL d25_s2: got %0d want 64", qs(2));
        end
        n_chk++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL d25_locked: got %b want 1", locked);
        end
    endtask

    task automatic test_duty0();
        int t1;
        qclear();
        pwm_frames(3, 0, t1);
        n_chk++;
        if (q_cyc.size() !== 3) begin
            n_err++;
            $display("FAIL d0_count: got %0d want 3", q_cyc.size());
        end
        n_chk++;
        if (qs(1) !== 0 || qs(2) !== 0) begin
            n_err++;
            $display("FAIL d0_vals: got %0d,%0d want 0,0",
                     qs(1), qs(2));
        end
        n_chk++;
        if (qc(1) !== t1 + P + L) begin
            n_err++;
            $display("FAIL d0_time: got %0d want %0d",
                     qc(1), t1 + P + L);
        end
        n_chk++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL d0_locked: got %b want 1", locked);
        end
    endtask

    task automatic test_duty100();
        int t2;
        qclear();
        pwm_frames(3, P, t2);
        n_chk++;
        if (qs(0) !== 0) begin
            n_err++;
            $display("FAIL d100_prev: got %0d want 0", qs(0));
        end
        n_chk++;
        if (qs(1) !== 255) begin
            n_err++;
            $display("FAIL d100_s1: got %0d want 255", qs(1));
        end
        n_chk++;
        if (qs(2) !== 255) begin
            n_err++;
            $display("FAIL d100_s2: got %0d want 255", qs(2));
        end
        n_chk++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL d100_locked: got %b want 1", locked);
        end
    endtask

    task automatic test_mid_edge();
        int ti;
        pwm_frames(1, 64, ti);
        pwm_part(100, 64);
        qclear();
        n_ferr = 0;
        pwm_frames(2, 64, ti);
        n_chk++;
        if (n_ferr !== 1) begin
            n_err++;
            $display("FAIL mid_ferr_n: got %0d want 1", n_ferr);
        end
        n_chk++;
        if (ferr_cyc !== ti + 1 + L) begin
            n_err++;
            $display("FAIL mid_ferr_t: got %0d want %0d",
                     ferr_cyc, ti + 1 + L);
        end
        n_chk++;
        if (ferr_locked !== 1'b0) begin
            n_err++;
            $display("FAIL mid_locked: got %b want 0", ferr_locked);
        end
        n_chk++;
        if (q_cyc.size() !== 1) begin
            n_err++;
            $display("FAIL mid_count: got %0d want 1", q_cyc.size());
        end
        n_chk++;
        if (qc(0) !== ti + P + L) begin
            n_err++;
            $display("FAIL mid_time: got %0d want %0d",
                     qc(0), ti + P + L);
        end
        n_chk++;
        if (qs(0) !== 64) begin
            n_err++;
            $display("FAIL mid_samp: got %0d want 64", qs(0));
        end
        n_chk++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL mid_relock: got %b want 1", locked);
        end
    endtask

    task automatic test_enable();
        int t;
        pwm_frames(2, 100, t);
        pwm_part(50, 100);
        @(negedge sysclk);
        Enable_SW_1 = 1'b0;
        Pulse       = 1'b0;
        qclear();
        idle(10);
        n_chk++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL en_locked: got %b want 0", locked);
        end
        n_chk++;
        if (sample !== 8'd100) begin
            n_err++;
            $display("FAIL en_hold: got %0d want 100", sample);
        end
        idle(989);
        n_chk++;
        if (q_cyc.size() !== 0) begin
            n_err++;
            $display("FAIL en_quiet: got %0d want 0", q_cyc.size());
        end
        n_chk++;
        if (sample !== 8'd100) begin
            n_err++;
            $display("FAIL en_hold2: got %0d want 100", sample);
        end
        @(negedge sysclk);
        Enable_SW_1 = 1'b1;
        idle(5);
        qclear();
        pwm_frames(2, 30, t);
        n_chk++;
        if (q_cyc.size() !== 1) begin
            n_err++;
            $display("FAIL en_count: got %0d want 1", q_cyc.size());
        end
        n_chk++;
        if (qc(0) !== t + P + L) begin
            n_err++;
            $display("FAIL en_time: got %0d want %0d",
                     qc(0), t + P + L);
        end
        n_chk++;
        if (qs(0) !== 30) begin
            n_err++;
            $display("FAIL en_samp: got %0d want 30", qs(0));
        end
    endtask

    task automatic test_reset_mid();
        int t;
        pwm_part(80, 30);
        @(negedge sysclk);
        reset = 1'b1;
        Pulse = 1'b0;
        @(negedge sysclk);
        n_chk++;
        if (sample !== 8'd0 || sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rm_sample: got %0d/%b want 0/0",
                     sample, sample_valid);
        end
        n_chk++;
        if (locked !== 1'b0 || frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL rm_status: got %b/%b want 0/0",
                     locked, frame_err);
        end
        reset = 1'b0;
        idle(5);
        qclear();
        pwm_frames(2, 200, t);
        n_chk++;
        if (q_cyc.size() !== 1) begin
            n_err++;
            $display("FAIL rm_count: got %0d want 1", q_cyc.size());
        end
        n_chk++;
        if (qc(0) !== t + P + L) begin
            n_err++;
            $display("FAIL rm_time: got %0d want %0d",
                     qc(0), t + P + L);
        end
        n_chk++;
        if (qs(0) !== 200) begin
            n_err++;
            $display("FAIL rm_samp: got %0d want 200", qs(0));
        end
    endtask

`ifdef PWM_DECODER_GLITCH_FILTER_EN
    task automatic test_glitch();
        int tg;
        int t;
        qclear();
        n_ferr = 0;
        tg = -1;
        for (int i = 0; i < P; i++) begin
            @(negedge sysclk);
            Pulse = (i < 64) || (i == 150);
            if (tg < 0) tg = cyc;
        end
        pwm_frames(1, 64, t);
        n_chk++;
        if (n_ferr !== 0) begin
            n_err++;
            $display("FAIL gl_ferr: got %0d want 0", n_ferr);
        end
        n_chk++;
        if (qs(1) !== 64) begin
            n_err++;
            $display("FAIL gl_samp: got %0d want 64", qs(1));
        end
        n_chk++;
        if (qc(1) !== tg + P + L) begin
            n_err++;
            $display("FAIL gl_time: got %0d want %0d",
                     qc(1), tg + P + L);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_duty25();
        test_duty0();
        test_duty100();
        test_mid_edge();
        test_enable();
        test_reset_mid();
`ifdef PWM_DECODER_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pwm_sample_decoder.md
# pwm_sample_decoder

Receive-side counterpart of the sawtooth/sine pulse generators: recovers sample values from a fixed-period PWM `Pulse` stream by counting high cycles per frame. Drives the loopback checker and captured-waveform readback. One sample is emitted per PWM period, with lock and framing-error status.

## Interface
- `PERIOD_CYCLES`, 256: sysclk cycles per PWM frame; must be ≥ 2.
- `SAMPLE_W`, 8: output sample width.
- `sysclk`  in  1  system clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Enable_SW_1`  in  1  decoder enable (level). Low forces IDLE.
- `Pulse`  in  1  PWM input, asynchronous to `sysclk`.
- `sample`  out  SAMPLE_W  last decoded high-cycle count, saturated.
- `sample_valid`  out  1  one-cycle strobe; `sample` is updated on the same cycle.
- `locked`  out  1  high after one clean frame.
- `frame_err`  out  1  one-cycle strobe when a rising edge arrives mid-frame.

## Operation
- Input path: 2-flop synchroniser, then rising-edge detect. This gives `p_s` (synced level) and `p_rise`.
- Counters: `period_cnt` is `$clog2(PERIOD_CYCLES)` bits wide and counts 0..PERIOD_CYCLES-1. `high_cnt` is `$clog2(PERIOD_CYCLES+1)` bits wide.
- FSM states: IDLE, ACQUIRE, TRACK.
- IDLE:
  - Counters are held at 0; `locked` is 0.
  - Moves to ACQUIRE when `Enable_SW_1` = 1.
- ACQUIRE:
  - Waits for `p_rise`.
  - On `p_rise`: next state TRACK, with `period_cnt` = 1 and `high_cnt` = 1 (the edge cycle counts as high).
- TRACK, every cycle:
  - `period_cnt` increments.
  - `high_cnt` increments when `p_s` = 1.
- Frame end (TRACK with `period_cnt` = PERIOD_CYCLES-1):
  - The final cycle's `p_s` is included in `high_cnt`.
  - Next cycle: `sample` = min(`high_cnt`, 2^SAMPLE_W-1), `sample_valid` = 1, `locked` = 1.
  - `period_cnt` wraps to 0 and `high_cnt` restarts. The new frame's first cycle counts `p_s`.
- Edge rules in TRACK:
  - `p_rise` with `period_cnt` = 0 is a legal frame start.
  - `p_rise` at any other count: `frame_err` pulses, `locked` clears, the partial frame is discarded with no `sample_valid`, and the frame restarts at that edge (`period_cnt` = 1, `high_cnt` = 1).
- 0% and 100% duty (no edges) stay locked and emit 0 and saturated max respectively, timed by `period_cnt`.
- `Enable_SW_1` falling in any state:
  - Next state IDLE, `locked` = 0.
  - The in-flight frame is dropped.
  - `sample` holds its last value.
- Simultaneous frame end and illegal `p_rise` cannot occur: `p_rise` at count 0 is always legal.

## Timing
- Reset values: `sample` = 0, `sample_valid` = 0, `locked` = 0, `frame_err` = 0, FSM = IDLE, counters = 0.
- Reset asserted mid-frame takes effect on the next edge. It overrides enable.
- Pin-to-`p_s` latency: 2 cycles.
- `sample_valid` occurs 1 cycle after the frame's last counted cycle, i.e. 3 cycles after the pin-level frame end.
- `frame_err` occurs 1 cycle after the offending `p_rise`.
- In steady state, `sample_valid` spacing is exactly PERIOD_CYCLES cycles.
- No back-pressure: consumers must capture `sample` on `sample_valid`.

## Configuration
- `PWM_DECODER_GLITCH_FILTER_EN` defined:
  - A 3-tap majority filter is inserted after the synchroniser, before edge detection and counting.
  - Adds 2 cycles to every latency above.
  - Single-cycle glitches on `Pulse` are rejected.
- Undefined: no filter; latencies as stated.

## Structure
- Package `pwm_decoder_pkg` holds:
  - the `dec_state_t` enum (IDLE, ACQUIRE, TRACK);
  - the `SYNC_STAGES` = 2 and `FILTER_TAPS` = 3 constants;
  - a saturating-truncate function.
- Sub-module `pulse_input_conditioner` contains the synchroniser, the optional majority filter and the edge detect. Its outputs are `p_s` and `p_rise`.
- Top level holds the FSM, counters and output registers.

## Test plan
- **25% duty:** PERIOD_CYCLES=256, SAMPLE_W=8, `Pulse` high 64 of every 256 cycles. Required: `locked` = 1 after the first frame, then `sample` = 64 with `sample_valid` every 256 cycles.
- **0% / 100% duty:** once locked, hold `Pulse` low for 3 frames → three `sample` = 0 strobes. Hold `Pulse` high for 3 frames → `sample` = 255 (saturated from 256).
- **Mid-frame edge:** rising edge injected at `period_cnt` = 100. Required: `frame_err` pulse, `locked` = 0, no strobe for that frame, next strobe 256 cycles after the injected edge.
- **Enable toggling:** `Enable_SW_1` low for 20000 ns mid-frame (20 ns clock). Required: IDLE, `locked` = 0, `sample` held. After re-enable, the first strobe comes one full frame after the next rising edge.
- **Reset mid-frame:** `reset` pulsed for one cycle. Required: all outputs 0 the next cycle, then ACQUIRE behaviour once `reset` is released.
- **Glitch filter (macro defined):** a 1-cycle high glitch inside a low region → no `frame_err`, unchanged sample. Latencies are +2 cycles.
